// File: rtl/skew_feed_if.sv
// Handshake/bus bundle between the skew-feed sequencer and its environment.
// The master drives tile commands; the slave (sequencer) drives bank reads and strobes.
interface skew_feed_if #(
  parameter int unsigned BUFFER_SIZE  = 9,
  parameter int unsigned BUFFER_COUNT = 16
);
  localparam int unsigned AW = $clog2(BUFFER_SIZE);
  localparam int unsigned KW = $clog2(BUFFER_SIZE + 1);

  logic                       start;
  logic [KW-1:0]              k_len;
  logic                       hold;
  logic [BUFFER_COUNT-1:0]    rd_en;
  logic [BUFFER_COUNT*AW-1:0] rd_addr;
  logic [BUFFER_COUNT-1:0]    in_valid;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output start, k_len, hold,
    input  rd_en, rd_addr, in_valid, busy, done, err
  );

  modport slave (
    input  start, k_len, hold,
    output rd_en, rd_addr, in_valid, busy, done, err
  );
endinterface

// File: rtl/skew_feed_ctrl.sv
// Diagonal-wavefront read sequencer for the operand skew-buffer bank.
// Lane 0 issues addresses 0..K-1; lane i replays lane 0 delayed i non-held cycles.
module skew_feed_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUFFER_SIZE  = 9,
  parameter int unsigned BUFFER_COUNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  skew_feed_if.slave  bus_io
);
  localparam int unsigned AW = $clog2(BUFFER_SIZE);
  localparam int unsigned KW = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned BC = BUFFER_COUNT;

  if (DATA_WIDTH == 0 || BUFFER_COUNT < 2 || BUFFER_SIZE < 2) begin : g_param_check
    $error("skew_feed_ctrl: unsupported parameter set");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [KW-1:0]    cnt_q, cnt_d;
  logic [BC-1:0]    pipe_en_q, pipe_en_d;
  logic [BC*AW-1:0] addr_q, addr_d;
  logic [BC-1:0]    rd_en_q, rd_en_d;
  logic [BC-1:0]    in_valid_q, in_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             last_q, last_d;

  logic             issue_en;
  logic [AW-1:0]    issue_addr;
  logic             k_legal;
  logic             can_start;
  logic             last_hit;

  assign k_legal   = (bus_io.k_len != '0) && (bus_io.k_len <= KW'(BUFFER_SIZE));
  assign can_start = ((state_q == StIdle) || (state_q == StFin)) && bus_io.start && !bus_io.hold;
  // Lane BC-1 is reading the final address; its in_valid follows regardless of hold.
  assign last_hit  = rd_en_q[BC-1] && (addr_q[(BC-1)*AW +: AW] == AW'(k_q - KW'(1)));

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    last_d     = last_q;
    issue_en   = 1'b0;
    issue_addr = '0;

    unique case (state_q)
      StIdle, StFin: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        last_d  = 1'b0;
        if (can_start) begin
          if (k_legal) begin
            k_d        = bus_io.k_len;
            cnt_d      = KW'(1);
            busy_d     = 1'b1;
            issue_en   = 1'b1;
            issue_addr = '0;
            state_d    = (bus_io.k_len == KW'(1)) ? StDrain : StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (!bus_io.hold) begin
          issue_en   = 1'b1;
          issue_addr = cnt_q[AW-1:0];
          cnt_d      = cnt_q + KW'(1);
          if (cnt_q == k_q - KW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (last_hit) begin
          last_d = 1'b1;
        end
        if (last_q && !bus_io.hold) begin
          state_d = StFin;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Wavefront pipeline: frozen under hold, while the read strobes are forced low.
  always_comb begin
    pipe_en_d  = pipe_en_q;
    addr_d     = addr_q;
    rd_en_d    = '0;
    in_valid_d = rd_en_q;
    if (!bus_io.hold) begin
      pipe_en_d = {pipe_en_q[BC-2:0], issue_en};
      addr_d    = {addr_q[(BC-1)*AW-1:0], issue_addr};
      rd_en_d   = pipe_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      cnt_q      <= '0;
      pipe_en_q  <= '0;
      addr_q     <= '0;
      rd_en_q    <= '0;
      in_valid_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      pipe_en_q  <= pipe_en_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      in_valid_q <= in_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      last_q     <= last_d;
    end
  end

  assign bus_io.rd_en    = rd_en_q;
  assign bus_io.rd_addr  = addr_q;
  assign bus_io.in_valid = in_valid_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.err      = err_q;
endmodule

// File: doc/skew_feed_ctrl.md
# skew_feed_ctrl

Sequencer for the 16-lane operand skew buffer bank that feeds the systolic array. On a start command it issues per-lane reads to the operand banks on a diagonal wavefront: lane i starts i cycles after lane 0. It drives each skew-buffer lane's `in_valid` when that lane's read data returns. It supports a global hold (back-pressure), rejects illegal tile depths, and signals completion once the last lane has been loaded.

## Interface
- `DATA_WIDTH`, 8: operand width; informational only, no data passes through this block.
- `BUFFER_SIZE`, 9: maximum tile depth K, equal to the skew-buffer lane depth.
- `BUFFER_COUNT`, 16: number of lanes.
- Derived: `AW = $clog2(BUFFER_SIZE)`, `KW = $clog2(BUFFER_SIZE+1)`.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a tile; accepted only when `busy`=0 and `hold`=0.
- `k_len`  in  KW  tile depth K, sampled with an accepted `start`; legal range 1..BUFFER_SIZE.
- `hold`  in  1  freeze issue of new reads and all schedule progress.
- `rd_en`  out  BUFFER_COUNT  per-lane read strobe to the operand banks; bank read latency is 1 cycle.
- `rd_addr`  out  BUFFER_COUNT*AW  per-lane read address; lane i occupies `[i*AW +: AW]`.
- `in_valid`  out  BUFFER_COUNT  per-lane capture strobe to the skew-buffer bank.
- `busy`  out  1  tile in progress.
- `done`  out  1  one-cycle pulse when the tile is complete.
- `err`  out  1  one-cycle pulse when `start` carries an illegal `k_len`.

## Operation
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE.
- FSM states:
  - IDLE: waits for start.
  - RUN: lane 0 issuing, addresses 0..K-1.
  - DRAIN: lane-0 issue finished, wavefront still propagating through lanes 1..BUFFER_COUNT-1.
  - FIN: single cycle.
- IDLE to RUN: `start`=1, `hold`=0, and 1 ≤ `k_len` ≤ BUFFER_SIZE. K is latched and `busy` is set.
- Illegal `k_len` (0 or > BUFFER_SIZE): `err` pulses the next cycle. The FSM stays in IDLE and `busy` stays 0.
- Schedule: lane 0 issues addresses 0..K-1 on consecutive non-held cycles. Lane i issues the same (en, addr) sequence delayed i non-held cycles. Implement as a BUFFER_COUNT-stage (en, addr) pipeline that advances only when `hold`=0.
- `in_valid[i]` = `rd_en[i]` registered one cycle. It is not gated by hold, so the read issued in the cycle before a hold is still reported.
- RUN to DRAIN: after lane 0 issues address K-1.
- DRAIN to FIN: after `in_valid[BUFFER_COUNT-1]` is asserted for address K-1.
- FIN: `done`=1 and `busy`=0; return to IDLE. A `start` in this cycle is accepted (back-to-back tiles).
- `start` while `busy`=1: ignored, no `err`.
- Hold: `hold` sampled high forces all `rd_en` to 0 the next cycle. The pipeline, address counter and FSM freeze. On release, issue resumes with the exact next address; no address is skipped or duplicated.
- Reset mid-tile: all outputs are 0 the next cycle and the pipeline is flushed. Reads or `in_valid` pending before the reset are never emitted afterwards.

## Timing
- Cycle 0: `start` accepted.
- Lane i issues address j in cycle 1+i+j, absent hold; `in_valid[i]` follows in cycle 2+i+j.
- `busy` is 1 from cycle 1 through cycle K+BUFFER_COUNT.
- `done` is in cycle K+BUFFER_COUNT+1, which is 26 for K=9, BUFFER_COUNT=16.
- Each held cycle delays every subsequent event by exactly 1 cycle.
- Each lane asserts `rd_en` exactly K times and `in_valid` exactly K times per tile, with addresses strictly ascending 0..K-1.
- `err` is in cycle 1 after an illegal `start`.

## Test plan
- Reset: hold `rst` for 3 cycles with random inputs. Required: all outputs 0 and FSM IDLE. First `start` after release is accepted normally.
- K=9, no hold, start in cycle 0. Required:
  - `rd_en[0]` high cycles 1..9 with addresses 0..8.
  - `rd_en[15]` high cycles 16..24.
  - `in_valid[15]` high cycles 17..25.
  - `done` in cycle 26; `busy` low in cycle 26.
- K=1: single diagonal. Required: `in_valid[i]` high only in cycle 2+i, and `done` in cycle 18. A second `start` in cycle 18 gives `rd_en[0]` in cycle 19.
- K=9 with `hold` high in cycles 5..7. Required:
  - All `rd_en` are 0 in cycles 6..8.
  - Lane 0 resumes in cycle 9 at address 5 (addresses 0..4 issued in cycles 1..5).
  - `done` in cycle 29.
  - Per-lane address order is unchanged.
- Illegal depth: `k_len`=0, then `k_len`=10. Required: `err` pulses in the cycle after each, with `busy` and `rd_en` remaining 0. Also, `start` during a busy tile produces no `err` and no change to the schedule.
- Reset in cycle 10 of a K=9 tile. Required: all outputs 0 from cycle 11 with no residual `in_valid`. A new K=4 `start` in cycle 12 gives `done` in cycle 33.
